// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: parametrised KMP pattern detector over a qualified symbol stream.
// The pattern is matched MSB-first. The state is the length of the longest pattern prefix
// that is also a suffix of the stream accepted so far.
// z is a registered one-cycle pulse for each completed match.
// Optional feature: define SEQ_DETECT_MATCH_CNT_EN to build a saturating match counter.
// Without it, match_cnt is tied to zero.
module seq_detect_fsm #(
  parameter int unsigned SYM_W   = 2,
  parameter int unsigned PAT_LEN = 4,
  parameter logic [SYM_W*PAT_LEN-1:0] PATTERN = 8'b10_01_10_01,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned ST_W   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] sym,
  output logic             z,
  output logic [ST_W-1:0]  state,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned NSYM = 1 << SYM_W;
  localparam int unsigned NST  = 1 << ST_W;

  if (PAT_LEN < 2) begin : g_bad_len
    $error("seq_detect_fsm: PAT_LEN must be >= 2");
  end
  if (SYM_W < 1) begin : g_bad_sym
    $error("seq_detect_fsm: SYM_W must be >= 1");
  end

  // Symbol i of the pattern, symbol 0 in the top bits.
  function automatic logic [SYM_W-1:0] pat_sym(input int unsigned i);
    return PATTERN[SYM_W*(PAT_LEN-i)-1 -: SYM_W];
  endfunction

  // Longest proper pattern prefix (< PAT_LEN) that is a suffix of P[0..k-1] followed by s.
  function automatic int unsigned next_k(input int unsigned k, input logic [SYM_W-1:0] s);
    int unsigned      best;
    int unsigned      idx;
    logic             ok;
    logic [SYM_W-1:0] t_sym;
    best = 0;
    for (int unsigned j = 1; j < PAT_LEN; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < j; i++) begin
          idx   = k + 1 - j + i;
          t_sym = (idx == k) ? s : pat_sym(idx);
          if (t_sym != pat_sym(i)) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Elaboration-time transition table. Rows beyond PAT_LEN-1 are unreachable padding
  // so that the state register can index the table directly.
  logic [ST_W-1:0] next_tbl [NST][NSYM];
  logic            hit_tbl  [NST][NSYM];

  for (genvar gk = 0; gk < NST; gk++) begin : g_k
    for (genvar gs = 0; gs < NSYM; gs++) begin : g_s
      if (gk < PAT_LEN) begin : g_used
        localparam bit HIT = (gk == PAT_LEN - 1) && (pat_sym(gk) == SYM_W'(gs));
        localparam int unsigned NXT = (HIT && OVERLAP == 0) ? 0 : next_k(gk, SYM_W'(gs));
        assign next_tbl[gk][gs] = ST_W'(NXT);
        assign hit_tbl[gk][gs]  = HIT;
      end else begin : g_pad
        assign next_tbl[gk][gs] = '0;
        assign hit_tbl[gk][gs]  = 1'b0;
      end
    end
  end

  logic [ST_W-1:0] state_q, state_d;
  logic            z_q, z_d;

  // Next state and match pulse. A gap holds the state and ignores sym.
  always_comb begin
    state_d = state_q;
    z_d     = 1'b0;
    if (in_valid) begin
      state_d = next_tbl[state_q][sym];
      z_d     = hit_tbl[state_q][sym];
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  assign state = state_q;
  assign z     = z_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of match pulses.
  always_comb begin
    cnt_d = cnt_q;
    if (z_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Testbench for seq_detect_fsm with four instances on a shared stimulus.
// Instance 0 uses the defaults. Instance 1 sets OVERLAP=0. Instance 2 sets CNT_W=2.
// Instance 3 uses SYM_W=1 with pattern 111 and is fed sym[0].
// A string-matching reference model predicts every output.
module tb_seq_detect_fsm;

  localparam int NI = 4;

  bit         clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] sym;

  logic       z_ov, z_nov, z_c2, z_same;
  logic [1:0] st_ov, st_nov, st_c2, st_same;
  logic [7:0] mc_ov, mc_nov, mc_same;
  logic [1:0] mc_c2;

  seq_detect_fsm u_ov (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sym(sym),
    .z(z_ov), .state(st_ov), .match_cnt(mc_ov));

  seq_detect_fsm #(.OVERLAP(0)) u_nov (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sym(sym),
    .z(z_nov), .state(st_nov), .match_cnt(mc_nov));

  seq_detect_fsm #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sym(sym),
    .z(z_c2), .state(st_c2), .match_cnt(mc_c2));

  seq_detect_fsm #(.SYM_W(1), .PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1)) u_same (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sym(sym[0:0]),
    .z(z_same), .state(st_same), .match_cnt(mc_same));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
    end
  endtask

  // Reference model: remembers the last few accepted symbols per instance and matches them against the pattern text.
  int plen [NI] = '{4, 4, 4, 3};
  int ovl  [NI] = '{1, 0, 1, 1};
  int cmax [NI] = '{255, 255, 3, 255};
  int smask[NI] = '{3, 3, 3, 1};
  int pat  [NI][4] = '{'{2, 1, 2, 1}, '{2, 1, 2, 1}, '{2, 1, 2, 1}, '{1, 1, 1, 0}};
  int hist [NI][4];
  int hlen [NI];
  int e_st [NI];
  int e_z  [NI];
  int e_cnt[NI];

  function automatic bit suffix_is_prefix(input int i, input int j);
    if (j > hlen[i]) return 1'b0;
    for (int t = 0; t < j; t++)
      if (pat[i][t] != hist[i][hlen[i] - j + t]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_accept(input int i, input int s);
    if (hlen[i] == plen[i]) begin
      for (int t = 0; t < plen[i] - 1; t++) hist[i][t] = hist[i][t + 1];
      hist[i][plen[i] - 1] = s;
    end else begin
      hist[i][hlen[i]] = s;
      hlen[i]++;
    end
    e_z[i] = 0;
    if (suffix_is_prefix(i, plen[i])) begin
      e_z[i] = 1;
      if (e_cnt[i] < cmax[i]) e_cnt[i]++;
      if (ovl[i] == 0) hlen[i] = 0;
    end
    e_st[i] = 0;
    for (int j = 1; j < plen[i]; j++)
      if (suffix_is_prefix(i, j)) e_st[i] = j;
  endtask

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst) begin
        hlen[i] = 0; e_st[i] = 0; e_z[i] = 0; e_cnt[i] = 0;
      end else if (in_valid) begin
        model_accept(i, int'(sym) & smask[i]);
      end else begin
        e_z[i] = 0;
      end
    end
  end

  function automatic int exp_cnt(input int i);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    return e_cnt[i];
`else
    return 0 * i;
`endif
  endfunction

  function automatic logic [31:0] act_st(input int i);
    case (i)
      0: return 32'(st_ov);
      1: return 32'(st_nov);
      2: return 32'(st_c2);
      default: return 32'(st_same);
    endcase
  endfunction

  function automatic logic [31:0] act_z(input int i);
    case (i)
      0: return 32'(z_ov);
      1: return 32'(z_nov);
      2: return 32'(z_c2);
      default: return 32'(z_same);
    endcase
  endfunction

  function automatic logic [31:0] act_cnt(input int i);
    case (i)
      0: return 32'(mc_ov);
      1: return 32'(mc_nov);
      2: return 32'(mc_c2);
      default: return 32'(mc_same);
    endcase
  endfunction

  // Compare every instance against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk("state", i, act_st(i), e_st[i]);
      chk("z", i, act_z(i), e_z[i]);
      chk("match_cnt", i, act_cnt(i), exp_cnt(i));
    end
  end

  // Drivers. Each call returns 3 ns after the edge that consumed the input.
  task automatic acc(input logic [1:0] s);
    in_valid = 1'b1;
    sym      = s;
    @(posedge clk);
    #3;
  endtask

  task automatic gap();
    in_valid = 1'b0;
    sym      = 2'bxx;
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_rst();
    rst = 1'b0;
    #10;
    rst = 1'b1;
  endtask

  int exp_c2[5] = '{1, 2, 3, 3, 3};
  int pidx;

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    sym      = 2'b10;
    #12;
    chk("lit_reset_state", 0, 32'(st_ov), 0);
    chk("lit_reset_z", 0, 32'(z_ov), 0);
    chk("lit_reset_cnt", 0, 32'(mc_ov), 0);
    #8;
    rst = 1'b1;
    @(posedge clk);
    #3;
    chk("lit_first_accept", 0, 32'(st_ov), 1);

    // Overlapping stream 10,01,10,01,10,01.
    acc(2'b01);
    acc(2'b10);
    acc(2'b01);
    chk("lit_ov_z4", 0, 32'(z_ov), 1);
    chk("lit_ov_st4", 0, 32'(st_ov), 2);
    chk("lit_nov_z4", 1, 32'(z_nov), 1);
    chk("lit_nov_st4", 1, 32'(st_nov), 0);
    acc(2'b10);
    chk("lit_ov_st5", 0, 32'(st_ov), 3);
    acc(2'b01);
    chk("lit_ov_z6", 0, 32'(z_ov), 1);
    chk("lit_ov_st6", 0, 32'(st_ov), 2);
    chk("lit_nov_z6", 1, 32'(z_nov), 0);
    chk("lit_nov_st6", 1, 32'(st_nov), 2);

    // Mismatch fallback.
    pulse_rst();
    acc(2'b10); acc(2'b01); acc(2'b10); acc(2'b10);
    chk("lit_fallback_st", 0, 32'(st_ov), 1);
    acc(2'b01); acc(2'b10); acc(2'b01);
    chk("lit_fallback_z", 0, 32'(z_ov), 1);
    chk("lit_fallback_st2", 0, 32'(st_ov), 2);

    // Gaps hold the partial match.
    pulse_rst();
    acc(2'b10); acc(2'b01);
    for (int g = 0; g < 5; g++) gap();
    chk("lit_gap_st", 0, 32'(st_ov), 2);
    chk("lit_gap_z", 0, 32'(z_ov), 0);
    acc(2'b10); acc(2'b01);
    chk("lit_gap_z_end", 0, 32'(z_ov), 1);

    // Asynchronous reset in the middle of a match.
    pulse_rst();
    acc(2'b10); acc(2'b01); acc(2'b10);
    chk("lit_pre_rst_st", 0, 32'(st_ov), 3);
    rst = 1'b0;
    #1;
    chk("lit_async_st", 0, 32'(st_ov), 0);
    chk("lit_async_z", 0, 32'(z_ov), 0);
    #9;
    rst = 1'b1;
    acc(2'b01);
    chk("lit_post_rst_st", 0, 32'(st_ov), 0);

    // Five overlapping matches for the 2-bit saturating counter.
    pulse_rst();
    acc(2'b10); acc(2'b01);
    for (int m = 0; m < 5; m++) begin
      acc(2'b10); acc(2'b01);
`ifdef SEQ_DETECT_MATCH_CNT_EN
      chk("lit_cnt_sat", 2, 32'(mc_c2), exp_c2[m]);
`else
      chk("lit_cnt_tied", 2, 32'(mc_c2), 0);
`endif
    end

    // Same-symbol pattern gives z on consecutive cycles.
    pulse_rst();
    acc(2'b01); acc(2'b01); acc(2'b01);
    chk("lit_same_z3", 3, 32'(z_same), 1);
    acc(2'b01);
    chk("lit_same_z4", 3, 32'(z_same), 1);
    chk("lit_same_st4", 3, 32'(st_same), 2);

    // Mixed stream biased toward the pattern, with gaps.
    pidx = 0;
    for (int c = 0; c < 120; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        gap();
      end else if ($urandom_range(0, 5) == 0) begin
        acc(2'($urandom_range(0, 3)));
      end else begin
        case (pidx % 4)
          0, 2:    acc(2'b10);
          default: acc(2'b01);
        endcase
        pidx++;
      end
    end
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
- Parametrised successor to the two-input Moore FSM.
- Detects a programmable pattern of PAT_LEN symbols, each SYM_W bits wide, in a qualified input stream.
- Pulses z for one cycle per detected match.
- Supports overlapping and non-overlapping detection and an optional saturating match counter.
- Used as a generic protocol/marker detector wherever a hard-coded x/y state machine was used before.

Parameters:
- SYM_W, 2, symbol width in bits (generalises the {x,y} pair); must be >= 1.
- PAT_LEN, 4, pattern length in symbols; must be >= 2 (elaboration error otherwise).
- PATTERN, 8'b10_01_10_01, SYM_W*PAT_LEN bits; symbol 0 = PATTERN[SYM_W*PAT_LEN-1 -: SYM_W], i.e. MSB-first.
- OVERLAP, 1, 1 = overlapping matches allowed, 0 = restart from empty after each match.
- CNT_W, 8, width of match_cnt (used only with MATCH_CNT_EN).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, sym is accepted on a rising clk edge only when in_valid=1.
- sym, input, SYM_W, input symbol.
- z, output, 1, registered one-cycle match pulse.
- state, output, ST_W = max(1,$clog2(PAT_LEN)), registered count of pattern symbols currently matched (0..PAT_LEN-1).
- match_cnt, output, CNT_W, saturating count of matches; tied to 0 without MATCH_CNT_EN.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed): state=0, z=0, match_cnt=0. All outputs are held while rst=0. The first accept occurs on the first rising edge with rst=1.
- The state encodes k = length of the longest prefix of PATTERN that is a suffix of the accepted stream, with k < PAT_LEN. This is a KMP automaton.
- Accept with sym == P[k] and k+1 < PAT_LEN: state <= k+1, z <= 0.
- Accept with sym == P[k] and k+1 == PAT_LEN (match):
  - z <= 1 for exactly the next cycle.
  - If OVERLAP=1: state <= F(PAT_LEN), the longest proper prefix of PATTERN that is also a suffix of PATTERN.
  - If OVERLAP=0: state <= 0.
- Accept with sym != P[k] (mismatch): state <= longest prefix of PATTERN that is a suffix of (P[0..k-1], sym). This may be 0 or any value <= k. No z.
- The failure/next-state table is computed from PATTERN by constant functions or generate logic at elaboration. There is no runtime pattern load.
- in_valid=0: state holds, z <= 0. Gaps never reset partial matches.
- Latency: z rises on the clock edge that accepts the final pattern symbol and is visible for that following cycle. Back-to-back matches with OVERLAP=1 can produce z on consecutive cycles when F(PAT_LEN)=PAT_LEN-1 (e.g. an all-same-symbol pattern).
- X on sym while in_valid=0 has no effect on state.
- Reset asserted mid-match: state and z clear immediately. A partially received pattern is discarded.
- The state output equals the internal state register. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- Defined: match_cnt increments by 1 on every edge that sets z <= 1 and saturates at 2^CNT_W-1 (no wrap). It is cleared only by rst.
- Undefined: no counter register is built; match_cnt is driven constant 0. All other behaviour is identical and the port list is unchanged.

Test Plan:
- Reset: rst=0 at t=0, released at 20 ns while feeding 10,01 -> state=0, z=0, match_cnt=0 throughout reset. Matching starts at the first edge after release.
- Overlap, defaults: accept 10,01,10,01,10,01 -> z pulses after the 4th and 6th symbols; state sequence 1,2,3,2(match),3,2(match).
- Non-overlap (OVERLAP=0): same stream -> a single z after the 4th symbol; final state=2.
- Mismatch fallback: accept 10,01,10,10 -> state 1,2,3,1; then 01,10,01 -> state 2,3,2 with z=1 after the last symbol.
- Gaps and reset mid-operation: 10,01,(in_valid=0 for 5 cycles),10,01 -> state holds at 2 during the gap and z fires once. Separately, at state=3, pulse rst low for 10 ns -> state=0 and z=0 immediately; then 01 -> state=0.
- Counter (SEQ_DETECT_MATCH_CNT_EN, CNT_W=2): 5 matches -> match_cnt 1,2,3,3,3. Without the macro -> match_cnt stays 0.
